alu_ctrl_stage: RTL
===================

Name: alu_ctrl_stage

Overview:
- Registered ALU control stage between ID and EX.
- Decodes opcode/funct into an ALU operation code using the codes in Opcode.v/Aluop.v.
- Registers the result with a valid bit, and tracks the in-flight multi-cycle HI/LO unit with a busy counter.
- Raises a stall request when a HI/LO consumer arrives while the unit is busy. Unknown encodings are flagged, never latched.

Parameters:
- ALUOP_W, 5, width of ALUop output; must hold every Aluop.v code.
- MULT_LATENCY, 4, cycles MULT/MUL occupy the HI/LO unit (>=1).
- DIV_LATENCY, 32, cycles DIV/DIVU occupy the HI/LO unit (only with feature).
- CNT_W, 6, busy counter width; must cover max latency.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  ID presents an instruction
- opcode  in  6  instruction [31:26]
- funct  in  6  instruction [5:0]
- ex_stall  in  1  EX/back end holding; stage register holds
- flush  in  1  squash stage contents (branch/exception)
- ALUop  out  ALUOP_W  registered ALU operation
- out_valid  out  1  ALUop is a live instruction
- illegal  out  1  registered: accepted instruction had no decode
- hilo_busy  out  1  HI/LO unit occupied
- stall_req  out  1  combinational: ID must hold current instruction

Behaviour:
- Reset, synchronous active-high: ALUop=ALU_ADDU, out_valid=0, illegal=0, counter=0, state IDLE. Reset overrides flush, ex_stall and busy.
- Decode is combinational, with a default arm for every path (no inferred latch):
  - RTYPE: each funct maps as in Aluop.v.
  - MULTYPE with funct MUL: ALU_MUL.
  - Loads/stores: ALU_ADDU.
  - Immediate ops map to their ALU ops.
  - Anything else: dec_illegal=1, op=ALU_ADDU.
- HI/LO users: MULT, MUL, MFHI, MFLO, MTHI, MTLO (+DIV/DIVU with feature). Issuers: MULT, MUL (+DIV/DIVU).
- stall_req = in_valid & hilo_user & hilo_busy.
- Register update priority per cycle:
  - reset.
  - ex_stall: hold all outputs; counter still decrements.
  - flush: out_valid=0, illegal=0.
  - stall_req: insert bubble, out_valid=0.
  - Otherwise load: ALUop=dec op, out_valid=in_valid, illegal=in_valid&dec_illegal.
- Latency: 1 cycle from accepted input to ALUop/out_valid.
- FSM IDLE/BUSY:
  - IDLE -> BUSY when an issuer is loaded (not stalled/flushed/ex_stalled); counter=LATENCY-1.
  - In BUSY the counter decrements every cycle, independent of ex_stall/flush. An issued op is committed; flush does not cancel it.
  - BUSY -> IDLE when the counter reaches 0 in that cycle.
  - hilo_busy=1 exactly while state==BUSY.
- Boundaries:
  - LATENCY=1: BUSY lasts one cycle. Back-to-back MULT stalls exactly 1 cycle.
  - A consumer arriving in the cycle the counter hits 0 is still stalled; it is accepted the next cycle.
  - An issuer cannot load while BUSY, because stall_req blocks it.
  - flush and stall_req together: bubble, stall_req still asserted.

Optional Feature:
- Macro ALU_CTRL_DIV_EN.
- Defined:
  - DIV/DIVU funct decode to ALU_DIV/ALU_DIVU.
  - They are issuers with DIV_LATENCY.
  - Counter loads DIV_LATENCY-1 for DIV, MULT_LATENCY-1 for MULT/MUL.
- Undefined: DIV/DIVU decode illegal; DIV_LATENCY is unused.

Test Plan:
- Reset then opcode=0x00 funct=0x20 in_valid=1 -> next cycle ALUop=ALU_ADD, out_valid=1, illegal=0, hilo_busy=0.
- MULT (0x00/0x18) then MFLO (0x00/0x12) back-to-back, MULT_LATENCY=4:
  - hilo_busy=1 for 4 cycles.
  - stall_req=1 for 4 cycles.
  - MFLO out_valid on the 6th cycle after MULT accepted.
  - Intervening bubbles have out_valid=0.
- MULT followed by LW (0x23) and ADDI (0x08) -> no stall; ALUop=ALU_ADDU then ALU_ADD while hilo_busy=1.
- opcode=0x3F in_valid=1 -> illegal=1, out_valid=1, ALUop=ALU_ADDU; next valid ADD clears illegal.
- ex_stall=1 for 3 cycles after MULT issue -> ALUop/out_valid held; hilo_busy drops on schedule (4 cycles). flush during BUSY -> out_valid=0, counter unaffected.
- With ALU_CTRL_DIV_EN, DIV (0x00/0x1A), DIV_LATENCY=32 -> hilo_busy 32 cycles. Without the macro -> illegal=1, no busy. Reset mid-BUSY -> hilo_busy=0 next cycle.

Source files
------------

// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - ID/EX ALU control register with HI/LO busy tracking and stall request
// Optional DIV/DIVU support is enabled by defining ALU_CTRL_DIV_EN.
module alu_ctrl_stage #(
    parameter int ALUOP_W      = 5,
    parameter int MULT_LATENCY = 4,
    parameter int DIV_LATENCY  = 32,
    parameter int CNT_W        = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               ex_stall,
    input  logic               flush,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               out_valid,
    output logic               illegal,
    output logic               hilo_busy,
    output logic               stall_req
);
    localparam logic [ALUOP_W-1:0] ALU_ADDU = ALUOP_W'(0),  ALU_ADD  = ALUOP_W'(1),
                                   ALU_SUB  = ALUOP_W'(2),  ALU_SUBU = ALUOP_W'(3),
                                   ALU_AND  = ALUOP_W'(4),  ALU_OR   = ALUOP_W'(5),
                                   ALU_XOR  = ALUOP_W'(6),  ALU_NOR  = ALUOP_W'(7),
                                   ALU_SLT  = ALUOP_W'(8),  ALU_SLTU = ALUOP_W'(9),
                                   ALU_SLL  = ALUOP_W'(10), ALU_SRL  = ALUOP_W'(11),
                                   ALU_SRA  = ALUOP_W'(12), ALU_SLLV = ALUOP_W'(13),
                                   ALU_SRLV = ALUOP_W'(14), ALU_SRAV = ALUOP_W'(15),
                                   ALU_MULT = ALUOP_W'(16), ALU_MUL  = ALUOP_W'(17),
                                   ALU_DIV  = ALUOP_W'(18), ALU_DIVU = ALUOP_W'(19),
                                   ALU_MFHI = ALUOP_W'(20), ALU_MFLO = ALUOP_W'(21),
                                   ALU_MTHI = ALUOP_W'(22), ALU_MTLO = ALUOP_W'(23),
                                   ALU_LUI  = ALUOP_W'(24);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_MULTYPE = 6'h1C,
                           OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                           OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F,
                           OP_LB    = 6'h20, OP_LH    = 6'h21, OP_LW   = 6'h23, OP_LBU   = 6'h24,
                           OP_LHU   = 6'h25, OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_SLLV = 6'h04,
                           F_SRLV = 6'h06, F_SRAV = 6'h07, F_MFHI = 6'h10, F_MTHI = 6'h11,
                           F_MFLO = 6'h12, F_MTLO = 6'h13, F_MULT = 6'h18, F_DIV  = 6'h1A,
                           F_DIVU = 6'h1B, F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22,
                           F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26,
                           F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B, F_MUL  = 6'h02;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    logic [ALUOP_W-1:0] w_dec_op;
    logic               w_dec_illegal;
    logic               w_is_div;
    logic               w_hilo_issuer;
    logic               w_hilo_user;
    logic               w_issue;
    logic [CNT_W-1:0]   w_lat_load;
    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [ALUOP_W-1:0] r_aluop;
    logic               r_valid;
    logic               r_illegal;

    always_comb begin
        w_dec_op      = ALU_ADDU;
        w_dec_illegal = 1'b0;
        w_is_div      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_SLL:  w_dec_op = ALU_SLL;
                    F_SRL:  w_dec_op = ALU_SRL;
                    F_SRA:  w_dec_op = ALU_SRA;
                    F_SLLV: w_dec_op = ALU_SLLV;
                    F_SRLV: w_dec_op = ALU_SRLV;
                    F_SRAV: w_dec_op = ALU_SRAV;
                    F_MFHI: w_dec_op = ALU_MFHI;
                    F_MTHI: w_dec_op = ALU_MTHI;
                    F_MFLO: w_dec_op = ALU_MFLO;
                    F_MTLO: w_dec_op = ALU_MTLO;
                    F_MULT: w_dec_op = ALU_MULT;
`ifdef ALU_CTRL_DIV_EN
                    F_DIV: begin
                        w_dec_op = ALU_DIV;
                        w_is_div = 1'b1;
                    end
                    F_DIVU: begin
                        w_dec_op = ALU_DIVU;
                        w_is_div = 1'b1;
                    end
`endif
                    F_ADD:  w_dec_op = ALU_ADD;
                    F_ADDU: w_dec_op = ALU_ADDU;
                    F_SUB:  w_dec_op = ALU_SUB;
                    F_SUBU: w_dec_op = ALU_SUBU;
                    F_AND:  w_dec_op = ALU_AND;
                    F_OR:   w_dec_op = ALU_OR;
                    F_XOR:  w_dec_op = ALU_XOR;
                    F_NOR:  w_dec_op = ALU_NOR;
                    F_SLT:  w_dec_op = ALU_SLT;
                    F_SLTU: w_dec_op = ALU_SLTU;
                    default: w_dec_illegal = 1'b1;
                endcase
            end
            OP_MULTYPE: begin
                if (funct == F_MUL) w_dec_op = ALU_MUL;
                else                w_dec_illegal = 1'b1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: w_dec_op = ALU_ADDU;
            OP_ADDI:  w_dec_op = ALU_ADD;
            OP_ADDIU: w_dec_op = ALU_ADDU;
            OP_SLTI:  w_dec_op = ALU_SLT;
            OP_SLTIU: w_dec_op = ALU_SLTU;
            OP_ANDI:  w_dec_op = ALU_AND;
            OP_ORI:   w_dec_op = ALU_OR;
            OP_XORI:  w_dec_op = ALU_XOR;
            OP_LUI:   w_dec_op = ALU_LUI;
            default:  w_dec_illegal = 1'b1;
        endcase
    end

    // Illegal decodes fall back to ADDU, so they can never look like a HI/LO op.
    assign w_hilo_issuer = !w_dec_illegal && (w_dec_op == ALU_MULT || w_dec_op == ALU_MUL ||
                                              w_dec_op == ALU_DIV  || w_dec_op == ALU_DIVU);
    assign w_hilo_user   = w_hilo_issuer || (!w_dec_illegal &&
                           (w_dec_op == ALU_MFHI || w_dec_op == ALU_MFLO ||
                            w_dec_op == ALU_MTHI || w_dec_op == ALU_MTLO));
    assign stall_req  = in_valid && w_hilo_user && (r_state == S_BUSY);
    assign w_issue    = in_valid && w_hilo_issuer && !ex_stall && !flush && !stall_req;
    assign w_lat_load = w_is_div ? CNT_W'(DIV_LATENCY - 1) : CNT_W'(MULT_LATENCY - 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_aluop   <= ALU_ADDU;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (ex_stall) begin
            r_aluop   <= r_aluop;
        end else if (flush || stall_req) begin
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_aluop   <= w_dec_op;
            r_valid   <= in_valid;
            r_illegal <= in_valid && w_dec_illegal;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Once issued the HI/LO op always runs to completion; ex_stall and flush do not pause it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = w_lat_load;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) w_state_nxt = S_IDLE;
                else             w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign ALUop     = r_aluop;
    assign out_valid = r_valid;
    assign illegal   = r_illegal;
    assign hilo_busy = (r_state == S_BUSY);
endmodule
